// File: rtl/rx_audio_drain.sv
// rx_audio_drain: drains one frame of audio sample words from the shared memory
// and streams it to the host as a header/timestamp/data/counter/checksum packet.
module rx_audio_drain #(
  parameter int NCHANS = 4,
  parameter int WPS    = 3,
  parameter int TMO    = 7
) (
  input  logic        cpu_clk,
  input  logic        reset_n,
  input  logic        srq_C,
  input  logic [7:0]  nsamps_C,
  input  logic [47:0] ticks_C,
  input  logic [15:0] buf_ctr_C,
  output logic        get_samp_C,
  input  logic        mem_rd_C,
  input  logic [15:0] mem_dout_C,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic        err,
  output logic [7:0]  overrun_cnt
);

  localparam int DW = $clog2(255*NCHANS*WPS+1);
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [DW-1:0] WPF      = DW'(NCHANS*WPS);
  localparam logic [DW-1:0] CNT_ONE  = DW'(1);
  localparam logic [DW-1:0] CNT_ZERO = DW'(0);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO-1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_TICK  = 3'd2;
  localparam logic [2:0] S_DREQ  = 3'd3;
  localparam logic [2:0] S_DWAIT = 3'd4;
  localparam logic [2:0] S_CTR   = 3'd5;
  localparam logic [2:0] S_SUM   = 3'd6;

  logic [2:0]    r_state;
  logic [7:0]    r_nsamps;
  logic [47:0]   r_ticks;
  logic [15:0]   r_buf_ctr;
  logic [DW-1:0] r_cnt;
  logic [15:0]   r_sum;
  logic [1:0]    r_tick_idx;
  logic [TW-1:0] r_tmo;
  logic          r_sum_sent;
  logic          r_out_valid;
  logic [15:0]   r_out_data;
  logic          r_out_last;
  logic          r_err;
  logic [7:0]    r_overrun;

  logic          w_can_load;
  logic          w_load;
  logic          w_tmo_hit;
  logic [15:0]   w_word;
  logic [DW-1:0] w_dcnt;

  // The output register may take a new word when empty or being accepted now.
  assign w_can_load = !r_out_valid || out_ready;
  assign w_dcnt     = DW'(nsamps_C) * WPF;
  assign w_tmo_hit  = (r_state == S_DWAIT) && !mem_rd_C && (r_tmo == TMO_LAST);

  always_comb begin
    w_load = 1'b0;
    w_word = 16'h0000;
    case (r_state)
      S_HDR: begin
        w_load = w_can_load;
        w_word = {8'hA5, r_nsamps};
      end
      S_TICK: begin
        w_load = w_can_load;
        case (r_tick_idx)
          2'd0:    w_word = r_ticks[47:32];
          2'd1:    w_word = r_ticks[31:16];
          default: w_word = r_ticks[15:0];
        endcase
      end
      S_DWAIT: begin
        // The register is already free here: the request was gated on it.
        w_load = mem_rd_C || w_tmo_hit;
        w_word = mem_rd_C ? mem_dout_C : 16'h0000;
      end
      S_CTR: begin
        w_load = w_can_load;
        w_word = r_buf_ctr;
      end
      S_SUM: begin
        w_load = w_can_load && !r_sum_sent;
        w_word = r_sum;
      end
      default: begin
        w_load = 1'b0;
        w_word = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_nsamps    <= 8'h00;
      r_ticks     <= 48'h0;
      r_buf_ctr   <= 16'h0000;
      r_cnt       <= CNT_ZERO;
      r_sum       <= 16'h0000;
      r_tick_idx  <= 2'd0;
      r_tmo       <= '0;
      r_sum_sent  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 16'h0000;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
      r_overrun   <= 8'h00;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_word;
        r_out_last  <= (r_state == S_SUM);
        r_sum       <= r_sum ^ w_word;
      end
      if (srq_C && (r_state != S_IDLE) && (r_overrun != 8'hFF))
        r_overrun <= r_overrun + 8'd1;

      case (r_state)
        S_IDLE: begin
          if (srq_C) begin
            r_nsamps   <= nsamps_C;
            r_ticks    <= ticks_C;
            r_buf_ctr  <= buf_ctr_C;
            r_cnt      <= w_dcnt;
            r_sum      <= 16'h0000;
            r_err      <= 1'b0;
            r_tick_idx <= 2'd0;
            r_sum_sent <= 1'b0;
            r_state    <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_load) r_state <= S_TICK;
        end
        S_TICK: begin
          if (w_load) begin
            r_tick_idx <= r_tick_idx + 2'd1;
            if (r_tick_idx == 2'd2)
              r_state <= (r_cnt == CNT_ZERO) ? S_CTR : S_DREQ;
          end
        end
        S_DREQ: begin
          if (w_can_load) begin
            r_tmo   <= '0;
            r_state <= S_DWAIT;
          end
        end
        S_DWAIT: begin
          if (w_load) begin
            r_cnt <= r_cnt - CNT_ONE;
            if (w_tmo_hit) r_err <= 1'b1;
            r_state <= (r_cnt == CNT_ONE) ? S_CTR : S_DREQ;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_CTR: begin
          if (w_load) r_state <= S_SUM;
        end
        S_SUM: begin
          if (!r_sum_sent) begin
            if (w_load) r_sum_sent <= 1'b1;
          end else if (r_out_valid && out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign get_samp_C  = (r_state == S_DREQ) && w_can_load;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign busy        = (r_state != S_IDLE);
  assign err         = r_err;
  assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_rx_audio_drain.sv
// tb_rx_audio_drain: scoreboard bench for rx_audio_drain with a 1-cycle-latency
// memory model, optional host backpressure and a droppable memory response.
module tb_rx_audio_drain;

  localparam int NCH = 4;
  localparam int WPS = 3;
  localparam int WPF = NCH * WPS;

  logic        cpu_clk;
  logic        reset_n;
  logic        srq_C;
  logic [7:0]  nsamps_C;
  logic [47:0] ticks_C;
  logic [15:0] buf_ctr_C;
  logic        get_samp_C;
  logic        mem_rd_C;
  logic [15:0] mem_dout_C;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        err;
  logic [7:0]  overrun_cnt;

  rx_audio_drain #(.NCHANS(NCH), .WPS(WPS), .TMO(7)) dut (
    .cpu_clk    (cpu_clk),
    .reset_n    (reset_n),
    .srq_C      (srq_C),
    .nsamps_C   (nsamps_C),
    .ticks_C    (ticks_C),
    .buf_ctr_C  (buf_ctr_C),
    .get_samp_C (get_samp_C),
    .mem_rd_C   (mem_rd_C),
    .mem_dout_C (mem_dout_C),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .err        (err),
    .overrun_cnt(overrun_cnt)
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
  } wordT;

  wordT        sbq[$];
  wordT        monE;
  int          totalCnt = 0;
  int          badCnt = 0;
  int          rxCount = 0;
  int          curLen = 0;
  int          getCount = 0;
  int          getBase = 0;
  int          reqCount = 0;
  int          dropIdx = 0;
  int          readyMode = 0;
  int          stallArm = 0;
  int          stallLeft = 0;
  logic        memPending = 1'b0;
  logic [15:0] memData = 16'h0000;
  logic        outstanding = 1'b0;
  logic        prevHold = 1'b0;
  logic [15:0] prevData = 16'h0000;

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    if (obs !== exp) begin
      badCnt++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Memory model: a request seen this cycle is answered during the next one.
  always @(negedge cpu_clk) begin
    if (reset_n && get_samp_C) begin
      getCount++;
      checkOutput("oneOutstanding", outstanding, 1'b0);
      reqCount++;
      if (reqCount != dropIdx) begin
        memPending  = 1'b1;
        memData     = 16'(reqCount);
        outstanding = 1'b1;
      end
    end
  end

  always @(posedge cpu_clk) begin
    #1;
    if (memPending) begin
      mem_rd_C    = 1'b1;
      mem_dout_C  = memData;
      memPending  = 1'b0;
      outstanding = 1'b0;
    end else begin
      mem_rd_C   = 1'b0;
      mem_dout_C = 16'hDEAD;
    end
  end

  always @(posedge cpu_clk) begin
    #1;
    if (readyMode == 0) begin
      out_ready = 1'b1;
    end else if (stallLeft > 0) begin
      out_ready = 1'b0;
      stallLeft--;
    end else if (stallArm != 0 && rxCount >= 8) begin
      stallArm  = 0;
      stallLeft = 19;
      out_ready = 1'b0;
    end else begin
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: scoreboard pops, hold-stability and out_last qualification.
  always @(negedge cpu_clk) begin
    if (!reset_n) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold)
        checkOutput("holdStable", {out_valid, out_data}, {1'b1, prevData});
      if (!out_valid)
        checkOutput("lastNoValid", out_last, 1'b0);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpectedWord", out_valid, 1'b0);
        end else begin
          monE = sbq.pop_front();
          checkOutput("word", out_data, monE.data);
          checkOutput("last", out_last, monE.last);
        end
        rxCount++;
      end
      prevHold = out_valid && !out_ready;
      prevData = out_data;
    end
  end

  task automatic pushFrame(input logic [7:0] ns, input logic [47:0] tk, input logic [15:0] bc, input int drop);
    logic [15:0] s;
    logic [15:0] w;
    int d;
    s = 16'h0000;
    w = {8'hA5, ns};
    sbq.push_back('{data: w, last: 1'b0}); s ^= w;
    w = tk[47:32]; sbq.push_back('{data: w, last: 1'b0}); s ^= w;
    w = tk[31:16]; sbq.push_back('{data: w, last: 1'b0}); s ^= w;
    w = tk[15:0];  sbq.push_back('{data: w, last: 1'b0}); s ^= w;
    d = int'(ns) * WPF;
    for (int k = 1; k <= d; k++) begin
      w = (k == drop) ? 16'h0000 : 16'(k);
      sbq.push_back('{data: w, last: 1'b0});
      s ^= w;
    end
    sbq.push_back('{data: bc, last: 1'b0}); s ^= bc;
    sbq.push_back('{data: s, last: 1'b1});
    curLen = d + 6;
  endtask

  task automatic applyStimulus(input logic [7:0] ns, input logic [47:0] tk, input logic [15:0] bc);
    @(posedge cpu_clk); #1;
    nsamps_C  = ns;
    ticks_C   = tk;
    buf_ctr_C = bc;
    srq_C     = 1'b1;
    @(posedge cpu_clk); #1;
    srq_C     = 1'b0;
    nsamps_C  = 8'h5A;
    ticks_C   = 48'hFFFF_0000_FFFF;
    buf_ctr_C = 16'h7777;
    checkOutput("busyN1", busy, 1'b1);
    checkOutput("errAtAccept", err, 1'b0);
    checkOutput("validN1", out_valid, 1'b0);
    @(posedge cpu_clk); #1;
    checkOutput("validN2", out_valid, 1'b1);
  endtask

  task automatic startFrame(input logic [7:0] ns, input logic [47:0] tk, input logic [15:0] bc, input int drop);
    pushFrame(ns, tk, bc, drop);
    reqCount = 0;
    dropIdx  = drop;
    rxCount  = 0;
    getBase  = getCount;
    applyStimulus(ns, tk, bc);
  endtask

  task automatic finishFrame();
    int n;
    n = 0;
    while ((busy || sbq.size() != 0) && n < 5000) begin
      @(posedge cpu_clk); #1;
      n++;
    end
    checkOutput("busyEnd", busy, 1'b0);
    checkOutput("sbLeft", sbq.size(), 0);
    checkOutput("frameLen", rxCount, curLen);
  endtask

  initial begin
    int n;
    logic found;
    reset_n    = 1'b0;
    srq_C      = 1'b0;
    nsamps_C   = 8'h00;
    ticks_C    = 48'h0;
    buf_ctr_C  = 16'h0000;
    mem_rd_C   = 1'b0;
    mem_dout_C = 16'h0000;
    out_ready  = 1'b1;
    repeat (3) @(posedge cpu_clk);
    #1;
    checkOutput("rstValid", out_valid, 1'b0);
    checkOutput("rstData", out_data, 16'h0000);
    checkOutput("rstLast", out_last, 1'b0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstErr", err, 1'b0);
    checkOutput("rstOvr", overrun_cnt, 8'h00);
    checkOutput("rstGet", get_samp_C, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(posedge cpu_clk);

    $display("[TB] basic frame nsamps=2");
    readyMode = 0;
    startFrame(8'd2, 48'h1234_5678_9ABC, 16'hBEEF, 0);
    finishFrame();
    checkOutput("errBasic", err, 1'b0);

    $display("[TB] empty frame nsamps=0");
    startFrame(8'd0, 48'hCAFE_0001_F00D, 16'h0042, 0);
    finishFrame();
    checkOutput("noGets", getCount - getBase, 0);

    $display("[TB] random backpressure with 20-cycle stall");
    readyMode = 1;
    stallArm  = 1;
    startFrame(8'd2, 48'h1234_5678_9ABC, 16'hBEEF, 0);
    finishFrame();
    readyMode = 0;
    checkOutput("stallDone", stallArm, 0);

    $display("[TB] memory timeout on word 5");
    startFrame(8'd2, 48'h0F0F_A0A0_5555, 16'h1357, 5);
    finishFrame();
    checkOutput("errSet", err, 1'b1);
    startFrame(8'd1, 48'h0000_0000_0001, 16'h2468, 0);
    finishFrame();
    checkOutput("errStaysClr", err, 1'b0);

    $display("[TB] overruns");
    startFrame(8'd3, 48'h1111_2222_3333, 16'h4444, 0);
    for (int i = 0; i < 3; i++) begin
      repeat (3) @(posedge cpu_clk);
      #1 srq_C = 1'b1;
      @(posedge cpu_clk);
      #1 srq_C = 1'b0;
    end
    found = 1'b0;
    n = 0;
    while (!found && n < 500) begin
      @(posedge cpu_clk); #1;
      n++;
      if (out_valid && out_last) begin
        srq_C = 1'b1;
        @(posedge cpu_clk); #1;
        srq_C = 1'b0;
        found = 1'b1;
      end
    end
    checkOutput("sumSeen", found, 1'b1);
    finishFrame();
    checkOutput("ovr4", overrun_cnt, 8'd4);
    repeat (10) @(posedge cpu_clk);
    #1;
    checkOutput("noExtraBusy", busy, 1'b0);
    checkOutput("noExtraWords", rxCount, curLen);

    startFrame(8'd30, 48'hABCD_EF01_2345, 16'h6789, 0);
    srq_C = 1'b1;
    repeat (300) @(posedge cpu_clk);
    #1 srq_C = 1'b0;
    checkOutput("ovrSat", overrun_cnt, 8'hFF);
    finishFrame();

    $display("[TB] reset mid-data");
    startFrame(8'd4, 48'h9999_8888_7777, 16'h6666, 0);
    n = 0;
    while (rxCount < 8 && n < 300) begin
      @(posedge cpu_clk); #1;
      n++;
    end
    checkOutput("reachedData", rxCount >= 8, 1'b1);
    reset_n = 1'b0;
    #1;
    checkOutput("arstValid", out_valid, 1'b0);
    checkOutput("arstData", out_data, 16'h0000);
    checkOutput("arstLast", out_last, 1'b0);
    checkOutput("arstBusy", busy, 1'b0);
    checkOutput("arstErr", err, 1'b0);
    checkOutput("arstOvr", overrun_cnt, 8'h00);
    checkOutput("arstGet", get_samp_C, 1'b0);
    sbq.delete();
    memPending  = 1'b0;
    outstanding = 1'b0;
    repeat (3) @(posedge cpu_clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge cpu_clk);
    startFrame(8'd2, 48'h0102_0304_0506, 16'h0A0B, 0);
    finishFrame();
    checkOutput("errAfterRst", err, 1'b0);

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
